// File: rtl/rv_core_pkg.sv
// Shared core definitions: register file geometry, index type and the
// writeback priority FSM encoding.
package rv_core_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;

    typedef enum logic [0:0] {
        MEM_PRI = 1'b0,
        ALU_PRI = 1'b1
    } pri_state_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write tracker with two combinational read ports
// for decode-stage RAW hazard checks.
module wb_scoreboard
    import rv_core_pkg::*;
#(
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          rs1_busy,
    output logic          rs2_busy
);

    localparam int N = 1 << AW;

    logic [N-1:0] pending_r;
    logic [N-1:0] set_mask_s;
    logic [N-1:0] clr_mask_s;
    logic [N-1:0] pending_nxt_s;

    // Next pending vector; a same-cycle set overrides the clear because a newer producer is in flight.
    always_comb begin
        set_mask_s    = {N{1'b0}};
        clr_mask_s    = {N{1'b0}};
        if (set_en && (set_idx != {AW{1'b0}})) begin
            set_mask_s[set_idx] = 1'b1;
        end else begin
            set_mask_s = {N{1'b0}};
        end
        if (clr_en) begin
            clr_mask_s[clr_idx] = 1'b1;
        end else begin
            clr_mask_s = {N{1'b0}};
        end
        pending_nxt_s    = (pending_r & ~clr_mask_s) | set_mask_s;
        pending_nxt_s[0] = 1'b0;
    end

    // Pending vector storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {N{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    assign rs1_busy = pending_r[rs1];
    assign rs2_busy = pending_r[rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port owner: arbitrates ALU and MEM writebacks with an
// anti-starvation priority FSM and tracks outstanding destination writes.
module regfile_wb_arbiter
    import rv_core_pkg::*;
#(
    parameter int DATA_W     = rv_core_pkg::DATA_W,
    parameter int ADDR_W     = rv_core_pkg::ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX - 1);

    pri_state_e         state_r;
    logic [CNT_W-1:0]   starve_cnt_r;
    logic               alu_gnt_s;
    logic               mem_gnt_s;
    logic               alu_lose_s;
    logic               wb_fire_s;
    logic [ADDR_W-1:0]  wb_rd_s;
    logic [DATA_W-1:0]  wb_data_s;

    // Grant selection: a lone requester always wins; on contention the FSM picks.
    always_comb begin
        alu_gnt_s = 1'b0;
        mem_gnt_s = 1'b0;
        if (alu_valid && mem_valid) begin
            if (state_r == ALU_PRI) begin
                alu_gnt_s = 1'b1;
            end else begin
                mem_gnt_s = 1'b1;
            end
        end else begin
            alu_gnt_s = alu_valid;
            mem_gnt_s = mem_valid;
        end
    end

    assign alu_ready  = alu_gnt_s;
    assign mem_ready  = mem_gnt_s;
    assign alu_lose_s = alu_valid & ~alu_gnt_s;
    assign wb_fire_s  = alu_gnt_s | mem_gnt_s;
    assign wb_rd_s    = alu_gnt_s ? alu_rd   : mem_rd;
    assign wb_data_s  = alu_gnt_s ? alu_data : mem_data;

    // Priority FSM: after STARVE_MAX consecutive ALU losses the ALU owns the next contended grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= MEM_PRI;
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                MEM_PRI: begin
                    if (alu_lose_s) begin
                        if (starve_cnt_r == STARVE_LAST) begin
                            state_r      <= ALU_PRI;
                            starve_cnt_r <= {CNT_W{1'b0}};
                        end else begin
                            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
                        end
                    end else if (alu_gnt_s) begin
                        starve_cnt_r <= {CNT_W{1'b0}};
                    end
                end
                ALU_PRI: begin
                    if (alu_gnt_s) begin
                        state_r      <= MEM_PRI;
                        starve_cnt_r <= {CNT_W{1'b0}};
                    end
                end
                default: begin
                    state_r      <= MEM_PRI;
                    starve_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Registered write port; x0 transfers complete the handshake but never write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= {ADDR_W{1'b0}};
            rf_wdata <= {DATA_W{1'b0}};
        end else if (wb_fire_s && (wb_rd_s != {ADDR_W{1'b0}})) begin
            rf_we    <= 1'b1;
            rf_rd    <= wb_rd_s;
            rf_wdata <= wb_data_s;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    wb_scoreboard #(
        .AW(ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_valid),
        .set_idx  (iss_rd),
        .clr_en   (wb_fire_s),
        .clr_idx  (wb_rd_s),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes expected writes,
// a negedge monitor compares grants, busy flags and the write port.
module tb_regfile_wb_arbiter;

    localparam int DW   = 64;
    localparam int AW   = 5;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, alu_ready, mem_valid, mem_ready, iss_valid;
    logic [AW-1:0] alu_rd, mem_rd, iss_rd, rs1, rs2, rf_rd;
    logic [DW-1:0] alu_data, mem_data, rf_wdata;
    logic          rs1_busy, rs2_busy, rf_we;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_t;

    int            n_checks = 0;
    int            n_errors = 0;
    wb_t           exp_q[$];
    logic [AW-1:0] wlog[$];
    logic [DW-1:0] dlog[$];
    logic [31:0]   pend_m;
    int            losses_m;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    // Monitor and reference model: ALU wins a contended cycle only after SMAX straight losses.
    initial begin
        wb_t  e;
        logic aw, mw;
        pend_m   = 32'd0;
        losses_m = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                pend_m   = 32'd0;
                losses_m = 0;
            end else begin
                chk("rf_we", {63'd0, rf_we}, (exp_q.size() != 0) ? 64'd1 : 64'd0);
                if (rf_we) begin
                    wlog.push_back(rf_rd);
                    dlog.push_back(rf_wdata);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (rf_we) begin
                        chk("rf_rd", {59'd0, rf_rd}, {59'd0, e.rd});
                        chk("rf_wdata", rf_wdata, e.data);
                    end
                end
                aw = alu_valid && (!mem_valid || (losses_m >= SMAX));
                mw = mem_valid && !aw;
                chk("alu_ready", {63'd0, alu_ready}, {63'd0, aw});
                chk("mem_ready", {63'd0, mem_ready}, {63'd0, mw});
                chk("rs1_busy", {63'd0, rs1_busy}, {63'd0, pend_m[rs1]});
                chk("rs2_busy", {63'd0, rs2_busy}, {63'd0, pend_m[rs2]});
                if (aw) begin
                    losses_m = 0;
                    if (alu_rd != 5'd0) exp_q.push_back('{alu_rd, alu_data});
                    pend_m[alu_rd] = 1'b0;
                end else if (alu_valid) begin
                    losses_m++;
                end
                if (mw) begin
                    if (mem_rd != 5'd0) exp_q.push_back('{mem_rd, mem_data});
                    pend_m[mem_rd] = 1'b0;
                end
                if (iss_valid && (iss_rd != 5'd0)) pend_m[iss_rd] = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] exp_seq [6];
        logic          a_acc, m_acc, accepted;
        int            n;
        exp_seq = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd7, 5'd3};
        rst_n = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
        alu_rd = 5'd0; mem_rd = 5'd0; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        alu_data = 64'd0; mem_data = 64'd0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset state
        @(posedge clk); #2;
        chk("reset_we", {63'd0, rf_we}, 64'd0);
        chk("reset_rd", {59'd0, rf_rd}, 64'd0);
        chk("reset_wdata", rf_wdata, 64'd0);
        chk("reset_alu_ready", {63'd0, alu_ready}, 64'd0);
        chk("reset_mem_ready", {63'd0, mem_ready}, 64'd0);

        // Single ALU writeback
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD_BEEF;
        #1 chk("single_ready", {63'd0, alu_ready}, 64'd1);
        @(posedge clk); #1;
        alu_valid = 1'b0;
        chk("single_we", {63'd0, rf_we}, 64'd1);
        chk("single_rd", {59'd0, rf_rd}, 64'd5);
        chk("single_wdata", rf_wdata, 64'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("single_we_drop", {63'd0, rf_we}, 64'd0);

        // Continuous contention
        wlog.delete();
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'h3333;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h7777;
        repeat (6) @(posedge clk);
        #1 mem_valid = 1'b0; alu_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("contend_count", wlog.size(), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < wlog.size()) chk("contend_seq", {59'd0, wlog[i]}, {59'd0, exp_seq[i]});
        end

        // x0 writeback and x0 issue
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 64'hBAD;
        iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
        #1 chk("x0_ready", {63'd0, mem_ready}, 64'd1);
        @(posedge clk); #1;
        mem_valid = 1'b0; iss_valid = 1'b0;
        chk("x0_we", {63'd0, rf_we}, 64'd0);
        chk("x0_busy", {63'd0, rs1_busy}, 64'd0);

        // Scoreboard set, set-wins, clear
        @(posedge clk); #1;
        iss_valid = 1'b1; iss_rd = 5'd9; rs1 = 5'd9;
        @(posedge clk); #1;
        iss_valid = 1'b0;
        chk("sb_set", {63'd0, rs1_busy}, 64'd1);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99; iss_valid = 1'b1; iss_rd = 5'd9;
        @(posedge clk); #1;
        alu_valid = 1'b0; iss_valid = 1'b0;
        chk("sb_set_wins", {63'd0, rs1_busy}, 64'd1);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h999;
        #1 chk("sb_busy_same_cycle", {63'd0, rs1_busy}, 64'd1);
        @(posedge clk); #1;
        alu_valid = 1'b0;
        chk("sb_clear", {63'd0, rs1_busy}, 64'd0);

        // Handshake hold: ALU waits out three MEM grants
        dlog.delete();
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 64'hA11A_0000_1234_5678;
        mem_valid = 1'b1; mem_rd = 5'd4;  mem_data = 64'h4444;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_not_ready", {63'd0, alu_ready}, 64'd0);
            @(posedge clk);
        end
        #1 mem_valid = 1'b0;
        accepted = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (alu_ready) begin
                accepted = 1'b1;
                @(posedge clk); #1;
                alu_valid = 1'b0;
                break;
            end
            @(posedge clk);
        end
        chk("hold_accept", {63'd0, accepted}, 64'd1);
        alu_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 n = 0;
        foreach (dlog[i]) if (dlog[i] == 64'hA11A_0000_1234_5678) n++;
        chk("hold_one_pulse", n, 64'd1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            a_acc = alu_valid && alu_ready;
            m_acc = mem_valid && mem_ready;
            @(posedge clk); #1;
            if (!alu_valid || a_acc) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd    = AW'($urandom_range(0, 31));
                alu_data  = {$urandom, $urandom};
            end
            if (!mem_valid || m_acc) begin
                mem_valid = ($urandom_range(0, 1) != 0);
                mem_rd    = AW'($urandom_range(0, 31));
                mem_data  = {$urandom, $urandom};
            end
            iss_valid = ($urandom_range(0, 1) != 0);
            iss_rd    = AW'($urandom_range(0, 31));
            rs1       = AW'($urandom_range(0, 31));
            rs2       = AW'($urandom_range(0, 31));
        end
        @(posedge clk); #1;
        alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
        @(posedge clk); #1;

        // Reset mid-operation
        alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 64'h1313;
        iss_valid = 1'b1; iss_rd = 5'd12; rs1 = 5'd12; rs2 = 5'd13;
        @(posedge clk); #1;
        alu_valid = 1'b0; iss_valid = 1'b0;
        chk("pre_reset_busy", {63'd0, rs1_busy}, 64'd1);
        chk("pre_reset_we", {63'd0, rf_we}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_we", {63'd0, rf_we}, 64'd0);
        chk("async_reset_rd", {59'd0, rf_rd}, 64'd0);
        chk("async_reset_wdata", rf_wdata, 64'd0);
        chk("async_reset_busy", {63'd0, rs1_busy}, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            rs1 = AW'(i);
            #1 chk("post_reset_busy", {63'd0, rs1_busy}, 64'd0);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
